// File: rtl/seq_nr_divider_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
interface seq_nr_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// Iterative non-restoring divider: one quotient bit per clock, unsigned or
// two's-complement operands, divide-by-zero short-circuited in one clock.
module seq_nr_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_nr_divider_if.slave    bus
);
    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    divs;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             q_neg;
    logic             r_neg;

    logic             dvd_neg_c;
    logic             dvs_neg_c;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [AW-1:0]    acc_sh_c;
    logic [AW-1:0]    acc_step_c;
    logic [AW-1:0]    acc_fix_c;
    logic [WIDTH-1:0] quo_res_c;
    logic [WIDTH-1:0] rem_res_c;

    // Operand magnitudes, one non-restoring step, and final sign/remainder fix-up
    always_comb begin
        dvd_neg_c  = bus.signed_mode & bus.dividend[WIDTH-1];
        dvs_neg_c  = bus.signed_mode & bus.divisor[WIDTH-1];
        dvd_mag_c  = dvd_neg_c ? (WIDTH'(0) - bus.dividend) : bus.dividend;
        dvs_mag_c  = dvs_neg_c ? (WIDTH'(0) - bus.divisor)  : bus.divisor;
        acc_sh_c   = {acc[WIDTH-1:0], quo[WIDTH-1]};
        acc_step_c = acc[WIDTH] ? (acc_sh_c + divs) : (acc_sh_c - divs);
        acc_fix_c  = acc[WIDTH] ? (acc + divs) : acc;
        quo_res_c  = q_neg ? (WIDTH'(0) - quo) : quo;
        rem_res_c  = r_neg ? (WIDTH'(0) - acc_fix_c[WIDTH-1:0]) : acc_fix_c[WIDTH-1:0];
    end

    // Control FSM and datapath registers; results only move on the done edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            acc             <= '0;
            divs            <= '0;
            quo             <= '0;
            count           <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                        end else begin
                            q_neg    <= dvd_neg_c ^ dvs_neg_c;
                            r_neg    <= dvd_neg_c;
                            acc      <= '0;
                            quo      <= dvd_mag_c;
                            divs     <= {1'b0, dvs_mag_c};
                            count    <= CW'(WIDTH);
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_step_c;
                    quo   <= {quo[WIDTH-2:0], ~acc_step_c[WIDTH]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    acc             <= acc_fix_c;
                    bus.quotient    <= quo_res_c;
                    bus.remainder   <= rem_res_c;
                    bus.div_by_zero <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_nr_divider.sv
// Bench for seq_nr_divider: directed vectors, handshake corner cases and
// randomized operations at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_seq_nr_divider;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    seq_nr_divider_if #(.WIDTH(8))  b8();
    seq_nr_divider_if #(.WIDTH(16)) b16();

    seq_nr_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    seq_nr_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output view of whichever instance is currently under test
    logic        cur_sel;
    logic [15:0] q_x;
    logic [15:0] r_x;
    logic        dz_x;
    logic        done_x;
    logic        busy_x;

    always_comb begin
        if (cur_sel) begin
            q_x    = b16.quotient;
            r_x    = b16.remainder;
            dz_x   = b16.div_by_zero;
            done_x = b16.done;
            busy_x = b16.busy;
        end else begin
            q_x    = {8'h00, b8.quotient};
            r_x    = {8'h00, b8.remainder};
            dz_x   = b8.div_by_zero;
            done_x = b8.done;
            busy_x = b8.busy;
        end
    end

    typedef struct {
        logic       sm;
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: integer division on sign-interpreted operands
    function automatic void model(input int w, input logic sm, input longint dvd,
                                  input longint dvs, output longint q, output longint r,
                                  output logic dz);
        longint mask;
        longint half;
        longint a;
        longint b;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        if (dvs == 0) begin
            q  = mask;
            r  = dvd;
            dz = 1'b1;
        end else begin
            dz = 1'b0;
            a  = dvd;
            b  = dvs;
            if (sm) begin
                if (a >= half) a = a - (longint'(1) << w);
                if (b >= half) b = b - (longint'(1) << w);
            end
            q = (a / b) & mask;
            r = (a % b) & mask;
        end
    endfunction

    task automatic start_op(input logic sel, input logic sm, input logic [15:0] dvd,
                            input logic [15:0] dvs);
        if (sel) begin
            b16.start       = 1'b1;
            b16.signed_mode = sm;
            b16.dividend    = dvd;
            b16.divisor     = dvs;
        end else begin
            b8.start       = 1'b1;
            b8.signed_mode = sm;
            b8.dividend    = dvd[7:0];
            b8.divisor     = dvs[7:0];
        end
        @(negedge clk);
        b8.start  = 1'b0;
        b16.start = 1'b0;
    endtask

    // lat counts clock edges after the start edge until done is seen
    task automatic wait_done(output int lat, output int busy_cycles, output logic ok);
        lat = 0;
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (done_x) begin
                ok = 1'b1;
                break;
            end
            if (busy_x) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic sel, input logic sm, input longint dvd, input longint dvs,
                          input longint exp_q, input longint exp_r, input logic exp_dz,
                          input string name);
        int   lat;
        int   bc;
        int   w;
        logic ok;
        w = sel ? 16 : 8;
        cur_sel = sel;
        start_op(sel, sm, 16'(dvd), 16'(dvs));
        wait_done(lat, bc, ok);
        check({name, " done_seen"}, longint'(ok), 1);
        check({name, " quotient"}, longint'(q_x), exp_q);
        check({name, " remainder"}, longint'(r_x), exp_r);
        check({name, " div_by_zero"}, longint'(dz_x), longint'(exp_dz));
        check({name, " latency"}, longint'(lat), exp_dz ? 0 : w + 1);
        check({name, " busy_cycles"}, longint'(bc), exp_dz ? 0 : w + 1);
        check({name, " busy_at_done"}, longint'(busy_x), 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   bc;
        logic ok;
        logic sm;
        longint dvd;
        longint dvs;
        longint eq;
        longint er;
        logic   ed;
        int     w;
        longint mask;

        checks  = 0;
        errors  = 0;
        cur_sel = 1'b0;
        rst_n   = 1'b0;
        b8.start = 1'b0;  b8.signed_mode = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        b16.start = 1'b0; b16.signed_mode = 1'b0; b16.dividend = '0; b16.divisor = '0;

        vecs.push_back('{1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0});
        vecs.push_back('{1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0});
        vecs.push_back('{1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 8'hF9,  8'h02, 8'h7C, 8'h01, 1'b0});
        vecs.push_back('{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd37,  8'h00, 8'hFF, 8'h25, 1'b1});
        vecs.push_back('{1'b1, 8'h25,  8'h00, 8'hFF, 8'h25, 1'b1});
        vecs.push_back('{1'b0, 8'd200, 8'd13, 8'd15, 8'd5,  1'b0});
        vecs.push_back('{1'b1, 8'h80,  8'h01, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'h81,  8'h10, 8'hF9, 8'hF1, 1'b0});
        vecs.push_back('{1'b0, 8'h03,  8'h09, 8'h00, 8'h03, 1'b0});

        repeat (3) @(negedge clk);
        check("rst busy8", longint'(b8.busy), 0);
        check("rst done8", longint'(b8.done), 0);
        check("rst quotient8", longint'(b8.quotient), 0);
        check("rst remainder8", longint'(b8.remainder), 0);
        check("rst dbz8", longint'(b8.div_by_zero), 0);
        check("rst quotient16", longint'(b16.quotient), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; consecutive ops start in the done cycle (back-to-back)
        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].sm, longint'(vecs[i].dvd), longint'(vecs[i].dvs),
                   longint'(vecs[i].exp_q), longint'(vecs[i].exp_r), vecs[i].exp_dz,
                   $sformatf("vec%0d", i));
        end

        // start pulsed mid-RUN with other operands must be ignored
        cur_sel = 1'b0;
        repeat (2) @(negedge clk);
        start_op(1'b0, 1'b0, 16'd100, 16'd7);
        repeat (3) @(negedge clk);
        b8.start = 1'b1; b8.dividend = 8'd50; b8.divisor = 8'd3;
        @(negedge clk);
        b8.start = 1'b0;
        wait_done(lat, bc, ok);
        check("midrun done_seen", longint'(ok), 1);
        check("midrun quotient", longint'(b8.quotient), 14);
        check("midrun remainder", longint'(b8.remainder), 2);
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b8.busy || b8.done) bc++;
        end
        check("midrun no_ghost_op", longint'(bc), 0);

        // Asynchronous reset in RUN clears held results immediately
        run_op(1'b0, 1'b0, 37, 0, 8'hFF, 8'h25, 1'b1, "pre_rst dbz");
        start_op(1'b0, 1'b0, 16'd100, 16'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", longint'(b8.busy), 0);
        check("async_rst done", longint'(b8.done), 0);
        check("async_rst quotient", longint'(b8.quotient), 0);
        check("async_rst remainder", longint'(b8.remainder), 0);
        check("async_rst dbz", longint'(b8.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 1'b0, 200, 13, 15, 5, 1'b0, "post_rst 200/13");

        // Randomized operations against the arithmetic model, both widths
        for (int s = 0; s < 2; s++) begin
            w    = (s == 1) ? 16 : 8;
            mask = (longint'(1) << w) - 1;
            for (int i = 0; i < 1000; i++) begin
                sm  = 1'($urandom);
                dvd = longint'($urandom) & mask;
                dvs = longint'($urandom) & mask;
                case ($urandom_range(0, 15))
                    0: dvs = 0;
                    1: begin dvd = longint'(1) << (w - 1); dvs = mask; end
                    2: dvs = 1;
                    3: dvd = mask;
                    default: ;
                endcase
                repeat ($urandom_range(0, 2)) @(negedge clk);
                model(w, sm, dvd, dvs, eq, er, ed);
                run_op(1'(s), sm, dvd, dvs, eq, er, ed,
                       $sformatf("rnd w%0d #%0d sm=%0d %0h/%0h", w, i, sm, dvd, dvs));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
